// File: rtl/game_pkg.sv
// Shared encodings for the whack-a-mole round controller: game states,
// display mode constants and the button bundle layout.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAYING   = 3'd2,
    PAUSED    = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  localparam logic DISP_SECS  = 1'b0;
  localparam logic DISP_SCORE = 1'b1;

  localparam int unsigned BTN_W = 3;

  // Bit order matches the concatenation {clear_hi, pause, start}.
  typedef struct packed {
    logic clear_hi;
    logic pause;
    logic start;
  } btn_t;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for a bank of debounced button levels.
module btn_edge_detect #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] rise_c
);

  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= btn;
  end

  assign rise_c = btn & ~prev_q;

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer: countdown, timed play with pause, high-score tracking,
// level latching and display selection, all driven from registers.
module game_round_controller
  import game_pkg::*;
#(
  parameter int unsigned SEC_W         = 6,
  parameter int unsigned COUNTDOWN_SEC = 5,
  parameter int unsigned GAME_SEC      = 30,
  parameter int unsigned NUM_LEVELS    = 3,
  parameter int unsigned LVL_W         = $clog2(NUM_LEVELS),
  parameter int unsigned SCORE_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_1hz,
  input  logic                  btn_start,
  input  logic                  btn_pause,
  input  logic                  btn_clear_hi,
  input  logic [NUM_LEVELS-1:0] level_sel,
  input  logic [SCORE_W-1:0]    score,
  output logic [2:0]            game_state,
  output logic [LVL_W-1:0]      level,
  output logic                  score_en,
  output logic                  score_clr,
  output logic                  mole_en,
  output logic [SEC_W-1:0]      secs_left,
  output logic [SCORE_W-1:0]    display_value,
  output logic                  display_mode,
  output logic [SCORE_W-1:0]    high_score,
  output logic                  new_high
);

  btn_t btn_now;
  btn_t btn_rise;

  assign btn_now = {btn_clear_hi, btn_pause, btn_start};

  btn_edge_detect #(.WIDTH(BTN_W)) u_btn_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn_now),
    .rise_c (btn_rise)
  );

  game_state_t         state_q, state_d;
  logic [SEC_W-1:0]    secs_q, secs_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [SCORE_W-1:0]  high_q, high_d;
  logic                new_high_q, new_high_d;
  logic                clr_q, clr_d;
  logic                run_q, run_d;
  logic [SCORE_W-1:0]  disp_val_q, disp_val_d;
  logic                disp_mode_q, disp_mode_d;
  logic                last_tick;

  assign last_tick = tick_1hz && (secs_q == SEC_W'(1));

  // Next-state: start edge overrides expiry, expiry overrides pause.
  always_comb begin
    state_d     = state_q;
    secs_d      = secs_q;
    level_d     = level_q;
    high_d      = high_q;
    new_high_d  = new_high_q;
    clr_d       = 1'b0;

    if (state_q == IDLE || state_q == GAME_OVER) begin
      if (btn_rise.clear_hi) begin
        high_d     = '0;
        new_high_d = 1'b0;
      end
      for (int i = int'(NUM_LEVELS) - 1; i >= 0; i--) begin
        if (level_sel[i]) level_d = LVL_W'(i);
      end
    end

    if (btn_rise.start) begin
      state_d    = COUNTDOWN;
      secs_d     = SEC_W'(COUNTDOWN_SEC);
      clr_d      = 1'b1;
      new_high_d = 1'b0;
    end else begin
      case (state_q)
        COUNTDOWN: begin
          if (last_tick) begin
            state_d = PLAYING;
            secs_d  = SEC_W'(GAME_SEC);
          end else if (tick_1hz) begin
            secs_d = secs_q - SEC_W'(1);
          end
        end
        PLAYING: begin
          if (last_tick) begin
            state_d = GAME_OVER;
            secs_d  = '0;
            if (score > high_q) begin
              high_d     = score;
              new_high_d = 1'b1;
            end
          end else begin
            if (tick_1hz)        secs_d  = secs_q - SEC_W'(1);
            if (btn_rise.pause)  state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (btn_rise.pause) state_d = PLAYING;
        end
        default: ;
      endcase
    end

    run_d = (state_d == PLAYING);

    case (state_d)
      IDLE: begin
        disp_val_d  = high_d;
        disp_mode_d = DISP_SCORE;
      end
      COUNTDOWN: begin
        disp_val_d  = SCORE_W'(secs_d);
        disp_mode_d = DISP_SECS;
      end
      default: begin
        disp_val_d  = score;
        disp_mode_d = DISP_SCORE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      secs_q      <= '0;
      level_q     <= '0;
      high_q      <= '0;
      new_high_q  <= 1'b0;
      clr_q       <= 1'b1;
      run_q       <= 1'b0;
      disp_val_q  <= '0;
      disp_mode_q <= DISP_SCORE;
    end else begin
      state_q     <= state_d;
      secs_q      <= secs_d;
      level_q     <= level_d;
      high_q      <= high_d;
      new_high_q  <= new_high_d;
      clr_q       <= clr_d;
      run_q       <= run_d;
      disp_val_q  <= disp_val_d;
      disp_mode_q <= disp_mode_d;
    end
  end

  assign game_state    = state_q;
  assign level         = level_q;
  assign score_en      = run_q;
  assign mole_en       = run_q;
  assign score_clr     = clr_q;
  assign secs_left     = secs_q;
  assign display_value = disp_val_q;
  assign display_mode  = disp_mode_q;
  assign high_score    = high_q;
  assign new_high      = new_high_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Directed scenarios plus a randomized run against a behavioural round model.
module tb_game_round_controller;

  localparam int CD_SEC   = 5;
  localparam int GAME_SEC = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_clear_hi = 1'b0;
  logic [2:0] level_sel = 3'b000;
  logic [7:0] score = 8'd0;
  logic [2:0] game_state;
  logic [1:0] level;
  logic       score_en, score_clr, mole_en;
  logic [5:0] secs_left;
  logic [7:0] display_value;
  logic       display_mode;
  logic [7:0] high_score;
  logic       new_high;

  int total = 0;
  int bad   = 0;

  game_round_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_1hz      (tick_1hz),
    .btn_start     (btn_start),
    .btn_pause     (btn_pause),
    .btn_clear_hi  (btn_clear_hi),
    .level_sel     (level_sel),
    .score         (score),
    .game_state    (game_state),
    .level         (level),
    .score_en      (score_en),
    .score_clr     (score_clr),
    .mole_en       (mole_en),
    .secs_left     (secs_left),
    .display_value (display_value),
    .display_mode  (display_mode),
    .high_score    (high_score),
    .new_high      (new_high)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase codes 0 idle, 1 countdown, 2 play, 3 paused, 4 over.
  int m_phase, m_secs, m_high, m_lvl, m_dval;
  bit m_nh, m_clr, m_dmode;
  bit p_start, p_pause, p_clear;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_secs = 0; m_high = 0; m_lvl = 0; m_nh = 0;
      m_clr = 1; m_dval = 0; m_dmode = 1;
      p_start = 0; p_pause = 0; p_clear = 0;
    end else begin
      bit e_start, e_pause, e_clear, found;
      e_start = btn_start & ~p_start;
      e_pause = btn_pause & ~p_pause;
      e_clear = btn_clear_hi & ~p_clear;
      p_start = btn_start; p_pause = btn_pause; p_clear = btn_clear_hi;
      m_clr = 0;
      if (m_phase == 0 || m_phase == 4) begin
        if (e_clear) begin m_high = 0; m_nh = 0; end
        found = 0;
        for (int i = 0; i < 3; i++)
          if (!found && level_sel[i]) begin m_lvl = i; found = 1; end
      end
      if (e_start) begin
        m_phase = 1; m_secs = CD_SEC; m_clr = 1; m_nh = 0;
      end else if (m_phase == 1 && tick_1hz) begin
        if (m_secs == 1) begin m_phase = 2; m_secs = GAME_SEC; end
        else m_secs = m_secs - 1;
      end else if (m_phase == 2) begin
        if (tick_1hz && m_secs == 1) begin
          m_phase = 4; m_secs = 0;
          if (int'(score) > m_high) begin m_high = int'(score); m_nh = 1; end
        end else begin
          if (tick_1hz) m_secs = m_secs - 1;
          if (e_pause) m_phase = 3;
        end
      end else if (m_phase == 3 && e_pause) begin
        m_phase = 2;
      end
      if (m_phase == 0)      begin m_dval = m_high;     m_dmode = 1; end
      else if (m_phase == 1) begin m_dval = m_secs;     m_dmode = 0; end
      else                   begin m_dval = int'(score); m_dmode = 1; end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1; cycle();
      tick_1hz = 1'b0; cycle();
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1; cycle();
    btn_start = 1'b0; cycle();
  endtask

  task automatic test_reset();
    total++; if (game_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", game_state); end
    total++; if (secs_left !== 6'd0 || level !== 2'd0) begin bad++; $display("FAIL reset_secs_level got=%0d/%0d exp=0/0", secs_left, level); end
    total++; if (high_score !== 8'd0 || new_high !== 1'b0) begin bad++; $display("FAIL reset_high got=%0d/%0b exp=0/0", high_score, new_high); end
    total++; if ({score_en, mole_en, score_clr} !== 3'b001) begin bad++; $display("FAIL reset_ctrl got=%b exp=001", {score_en, mole_en, score_clr}); end
    total++; if (display_value !== 8'd0 || display_mode !== 1'b1) begin bad++; $display("FAIL reset_disp got=%0d/%0b exp=0/1", display_value, display_mode); end
  endtask

  task automatic test_level_idle();
    level_sel = 3'b110; cycle(); level_sel = 3'b000;
    total++; if (level !== 2'd1) begin bad++; $display("FAIL level_idle got=%0d exp=1", level); end
  endtask

  task automatic test_countdown();
    btn_start = 1'b1; cycle();
    total++; if (score_clr !== 1'b1 || game_state !== 3'd1) begin bad++; $display("FAIL cd_start got clr=%0b st=%0d exp clr=1 st=1", score_clr, game_state); end
    btn_start = 1'b0; cycle();
    total++; if (score_clr !== 1'b0) begin bad++; $display("FAIL cd_clr_width got=%0b exp=0", score_clr); end
    for (int i = 0; i < CD_SEC; i++) begin
      total++; if (int'(secs_left) !== CD_SEC - i || display_mode !== 1'b0) begin bad++; $display("FAIL cd_secs got=%0d exp=%0d", secs_left, CD_SEC - i); end
      ticks(1);
    end
    total++; if (game_state !== 3'd2 || int'(secs_left) !== GAME_SEC) begin bad++; $display("FAIL cd_to_play got st=%0d secs=%0d exp st=2 secs=30", game_state, secs_left); end
    total++; if (score_en !== 1'b1 || mole_en !== 1'b1) begin bad++; $display("FAIL play_en got=%0b%0b exp=11", score_en, mole_en); end
  endtask

  task automatic test_pause();
    ticks(10);
    total++; if (secs_left !== 6'd20) begin bad++; $display("FAIL pause_pre got=%0d exp=20", secs_left); end
    level_sel = 3'b100; btn_pause = 1'b1; cycle(); btn_pause = 1'b0; level_sel = 3'b000;
    total++; if (game_state !== 3'd3 || score_en !== 1'b0 || mole_en !== 1'b0) begin bad++; $display("FAIL pause_enter got st=%0d en=%0b%0b exp st=3 en=00", game_state, score_en, mole_en); end
    total++; if (level !== 2'd1) begin bad++; $display("FAIL level_play got=%0d exp=1", level); end
    ticks(7);
    total++; if (secs_left !== 6'd20 || score_en !== 1'b0) begin bad++; $display("FAIL pause_frozen got secs=%0d en=%0b exp secs=20 en=0", secs_left, score_en); end
    btn_pause = 1'b1; cycle(); btn_pause = 1'b0;
    total++; if (game_state !== 3'd2 || secs_left !== 6'd20 || score_en !== 1'b1) begin bad++; $display("FAIL pause_resume got st=%0d secs=%0d exp st=2 secs=20", game_state, secs_left); end
  endtask

  task automatic test_high_score();
    score = 8'd42;
    ticks(20);
    total++; if (game_state !== 3'd4 || high_score !== 8'd42 || new_high !== 1'b1) begin bad++; $display("FAIL hs_first got st=%0d hs=%0d nh=%0b exp st=4 hs=42 nh=1", game_state, high_score, new_high); end
    total++; if (display_value !== 8'd42 || display_mode !== 1'b1) begin bad++; $display("FAIL hs_disp got=%0d/%0b exp=42/1", display_value, display_mode); end
    press_start();
    total++; if (new_high !== 1'b0) begin bad++; $display("FAIL hs_nh_clear got=%0b exp=0", new_high); end
    ticks(CD_SEC + GAME_SEC);
    total++; if (game_state !== 3'd4 || high_score !== 8'd42 || new_high !== 1'b0) begin bad++; $display("FAIL hs_equal got st=%0d hs=%0d nh=%0b exp st=4 hs=42 nh=0", game_state, high_score, new_high); end
  endtask

  task automatic test_expiry_races();
    press_start(); ticks(CD_SEC);
    btn_clear_hi = 1'b1; cycle(); btn_clear_hi = 1'b0;
    total++; if (high_score !== 8'd42) begin bad++; $display("FAIL clear_in_play got=%0d exp=42", high_score); end
    ticks(GAME_SEC - 1);
    tick_1hz = 1'b1; btn_pause = 1'b1; cycle(); tick_1hz = 1'b0; btn_pause = 1'b0;
    total++; if (game_state !== 3'd4 || secs_left !== 6'd0) begin bad++; $display("FAIL pause_on_expiry got st=%0d secs=%0d exp st=4 secs=0", game_state, secs_left); end
    btn_clear_hi = 1'b1; cycle(); btn_clear_hi = 1'b0;
    total++; if (high_score !== 8'd0 || new_high !== 1'b0) begin bad++; $display("FAIL clear_in_over got=%0d/%0b exp=0/0", high_score, new_high); end
    press_start(); ticks(CD_SEC + GAME_SEC - 1);
    tick_1hz = 1'b1; btn_start = 1'b1; cycle(); tick_1hz = 1'b0; btn_start = 1'b0;
    total++; if (game_state !== 3'd1 || int'(secs_left) !== CD_SEC || high_score !== 8'd0) begin bad++; $display("FAIL start_on_expiry got st=%0d secs=%0d hs=%0d exp st=1 secs=5 hs=0", game_state, secs_left, high_score); end
  endtask

  task automatic test_async_reset();
    ticks(CD_SEC + 3);
    #2 rst_n = 1'b0;
    #1;
    total++; if (game_state !== 3'd0 || level !== 2'd0 || secs_left !== 6'd0) begin bad++; $display("FAIL async_rst got st=%0d lvl=%0d secs=%0d exp 0/0/0", game_state, level, secs_left); end
    total++; if ({score_en, mole_en, score_clr, display_mode} !== 4'b0011 || display_value !== 8'd0) begin bad++; $display("FAIL async_rst_out got=%b/%0d exp=0011/0", {score_en, mole_en, score_clr, display_mode}, display_value); end
    @(negedge clk); rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      tick_1hz = ($urandom % 3 == 0);
      if ($urandom % 150 == 0) btn_start = ~btn_start;
      if ($urandom % 25 == 0)  btn_pause = ~btn_pause;
      if ($urandom % 60 == 0)  btn_clear_hi = ~btn_clear_hi;
      level_sel = ($urandom % 10 == 0) ? 3'($urandom) : 3'b000;
      score = 8'($urandom);
      cycle();
      total++;
      if (int'(game_state) !== m_phase || int'(secs_left) !== m_secs || int'(level) !== m_lvl ||
          int'(high_score) !== m_high || new_high !== m_nh || score_clr !== m_clr ||
          score_en !== (m_phase == 2) || mole_en !== (m_phase == 2) ||
          int'(display_value) !== m_dval || display_mode !== m_dmode) begin
        bad++;
        $display("FAIL rand_cycle%0d got st=%0d s=%0d l=%0d hs=%0d nh=%0b clr=%0b en=%0b dv=%0d dm=%0b exp st=%0d s=%0d l=%0d hs=%0d nh=%0b clr=%0b dv=%0d dm=%0b",
                 n, game_state, secs_left, level, high_score, new_high, score_clr, score_en, display_value, display_mode,
                 m_phase, m_secs, m_lvl, m_high, m_nh, m_clr, m_dval, m_dmode);
      end
    end
  endtask

  initial begin
    #12 rst_n = 1'b1;
    test_reset();
    test_level_idle();
    test_countdown();
    test_pause();
    test_high_score();
    test_expiry_races();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
Parametrised top-level game sequencer for the whack-a-mole design. It counts countdown and play time internally from a 1 Hz strobe, and adds a pause state. It tracks a persistent high score and supports N selectable difficulty levels. It drives the enables and clears for the score counter and mole controller, and the value and mode shown on the display.

Parameters:
- SEC_W, 6, width of the seconds counters
- COUNTDOWN_SEC, 5, countdown length in seconds (1..2^SEC_W-1)
- GAME_SEC, 30, play length in seconds (1..2^SEC_W-1)
- NUM_LEVELS, 3, number of difficulty levels (>=2)
- LVL_W, $clog2(NUM_LEVELS), width of the level index
- SCORE_W, 8, score width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  single-cycle strobe, clk domain, once per second
- btn_start  in  1  debounced level; rising edge starts or restarts a round
- btn_pause  in  1  debounced level; rising edge toggles pause
- btn_clear_hi  in  1  debounced level; rising edge clears the high score
- level_sel  in  NUM_LEVELS  one-hot level request
- score  in  SCORE_W  current score from the score counter
- game_state  out  3  encoded state
- level  out  LVL_W  latched difficulty
- score_en  out  1  score counter enable
- score_clr  out  1  one-cycle score clear pulse
- mole_en  out  1  mole controller enable
- secs_left  out  SEC_W  remaining seconds in the current phase
- display_value  out  SCORE_W  value to display
- display_mode  out  1  0 = seconds, 1 = score
- high_score  out  SCORE_W  best score since reset or clear
- new_high  out  1  set in GAME_OVER when the last round set a record

Behaviour:
- Reset (async): state IDLE; level 0; secs_left 0; high_score 0; new_high 0; score_en 0; mole_en 0; score_clr 1; display_value 0; display_mode 1; edge-detector history 0.
- Edges: edge = btn & ~btn_prev. An edge acts on the clk edge where it is detected. All outputs are registered or decoded from registers only; there is no input-to-output combinational path.
- States: IDLE, COUNTDOWN, PLAYING, PAUSED, GAME_OVER.
- Priority per cycle: start edge > timer expiry > pause edge.
- IDLE:
  - start edge -> COUNTDOWN; secs_left <= COUNTDOWN_SEC; score_clr pulses for 1 cycle.
- COUNTDOWN:
  - tick with secs_left > 1 -> secs_left decrements.
  - tick with secs_left == 1 -> PLAYING; secs_left <= GAME_SEC.
  - pause edge is ignored.
- PLAYING:
  - tick decrements secs_left.
  - tick with secs_left == 1 -> GAME_OVER; secs_left <= 0; the high-score compare happens on this same edge.
  - pause edge without expiry -> PAUSED.
- PAUSED:
  - ticks are ignored and secs_left is frozen.
  - pause edge -> PLAYING with secs_left unchanged.
- GAME_OVER:
  - holds until a start edge.
- Start edge in any state except IDLE -> COUNTDOWN; secs_left <= COUNTDOWN_SEC; score_clr pulses; new_high <= 0.
- score_en = mole_en = 1 only in PLAYING. Both are 0 in PAUSED, so the score freezes.
- High score:
  - On the PLAYING->GAME_OVER edge, if score > high_score then high_score <= score and new_high <= 1. An equal score is not a record.
  - Clear-high edge in IDLE or GAME_OVER -> high_score <= 0 and new_high <= 0. It is ignored in other states.
- Level:
  - Updated only in IDLE or GAME_OVER.
  - level_sel == 0 leaves the level unchanged.
  - With multiple bits set, the lowest index wins.
  - Bits at index >= NUM_LEVELS do not exist.
- Display:
  - IDLE: high_score, mode 1.
  - COUNTDOWN: zero-extended secs_left, mode 0.
  - PLAYING, PAUSED, GAME_OVER: score, mode 1.
- Buttons held high produce only one edge. A start edge on the same cycle as expiry resolves to COUNTDOWN and the high score is not updated.

Decomposition:
- Package game_pkg holds:
  - the state encoding: IDLE=0, COUNTDOWN=1, PLAYING=2, PAUSED=3, GAME_OVER=4;
  - the DISP_SECS=0 and DISP_SCORE=1 constants.
- One sub-module, btn_edge_detect: parametrised width (3 here), registered history, async active-low reset, combinational rising-edge output.

Test Plan:
- Reset, start edge, then 5 ticks. Required: secs_left 5,4,3,2,1, then state PLAYING with secs_left 30. score_clr is high exactly 1 cycle after the start edge.
- In PLAYING after 10 ticks (secs_left 20): pause edge, 7 ticks, pause edge. Required: secs_left stays 20, score_en 0 while paused, state PLAYING after the second edge.
- Full game with score=42 and high_score=0. Required: GAME_OVER, high_score 42, new_high 1. Second game with score 42: high_score stays 42, new_high 0.
- Pause edge and final tick on the same cycle (secs_left 1). Required: GAME_OVER, not PAUSED. Start edge on an expiry tick: COUNTDOWN with secs_left 5 and high_score unchanged.
- level_sel=3'b110 in IDLE. Required: level 1. level_sel=3'b100 during PLAYING: level unchanged.
- Clear-high edge in PLAYING: high_score unchanged. Clear-high edge in GAME_OVER: high_score 0. Assert rst_n mid-PLAYING: state is IDLE and outputs hold their reset values immediately, with no clock edge required.
